// File: rtl/rvcam_imm_pkg.sv
// -----------------------------------------------------------------------------
// rvcam_imm_pkg
//   Shared definitions for the immediate-extraction path: the immediate format
//   encoding and the bit counts of each immediate format.
// -----------------------------------------------------------------------------
package rvcam_imm_pkg;

    localparam int IMM_TYPE_W = 3;

    typedef enum logic [IMM_TYPE_W-1:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_U   = 3'd3,
        IMM_J   = 3'd4,
        IMM_Z   = 3'd5,
        IMM_SH  = 3'd6,
        IMM_RSV = 3'd7
    } imm_type_e;

    // Significant bits of each format before extension (sign bit included).
    localparam int I_BITS    = 12;
    localparam int S_BITS    = 12;
    localparam int B_BITS    = 13;
    localparam int U_BITS    = 32;
    localparam int J_BITS    = 21;
    localparam int Z_BITS    = 5;
    localparam int SH32_BITS = 5;
    localparam int SH64_BITS = 6;

endpackage

// File: rtl/imm_decode_stage_imm_expand.sv
// -----------------------------------------------------------------------------
// imm_expand
//   Combinational immediate extractor. Gathers the scattered immediate bits of
//   an instruction word and extends them to XLEN.
//   Ports:
//     i_instr     [31:7]  instruction bits (opcode field not needed)
//     i_imm_type  imm_type_e immediate format
//     o_imm       [XLEN-1:0] extended immediate
//     o_illegal   reserved format requested (o_imm forced to 0)
// -----------------------------------------------------------------------------
module imm_expand
    import rvcam_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_instr,
    input  imm_type_e       i_imm_type,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    // Each signed format is first assembled as a 32-bit signed value so that a
    // single size cast performs the sign extension for either XLEN.
    logic signed [31:0] w_i_imm;
    logic signed [31:0] w_s_imm;
    logic signed [31:0] w_b_imm;
    logic signed [31:0] w_u_imm;
    logic signed [31:0] w_j_imm;
    logic [Z_BITS-1:0]    w_z_imm;
    logic [SH64_BITS-1:0] w_sh_imm;

    assign w_i_imm = 32'(signed'(i_instr[31:20]));
    assign w_s_imm = 32'(signed'({i_instr[31:25], i_instr[11:7]}));
    assign w_b_imm = 32'(signed'({i_instr[31], i_instr[7], i_instr[30:25],
                                  i_instr[11:8], 1'b0}));
    assign w_u_imm = {i_instr[31:12], 12'b0};
    assign w_j_imm = 32'(signed'({i_instr[31], i_instr[19:12], i_instr[20],
                                  i_instr[30:21], 1'b0}));
    assign w_z_imm = i_instr[19:15];
    // Bit 25 belongs to the shift amount only on 64-bit datapaths.
    assign w_sh_imm = (XLEN == 64) ? i_instr[25:20] : {1'b0, i_instr[24:20]};

    always_comb begin
        o_imm     = '0;
        o_illegal = 1'b0;
        unique case (i_imm_type)
            IMM_I:   o_imm = XLEN'(w_i_imm);
            IMM_S:   o_imm = XLEN'(w_s_imm);
            IMM_B:   o_imm = XLEN'(w_b_imm);
            IMM_U:   o_imm = XLEN'(w_u_imm);
            IMM_J:   o_imm = XLEN'(w_j_imm);
            IMM_Z:   o_imm = XLEN'(w_z_imm);
            IMM_SH:  o_imm = XLEN'(w_sh_imm);
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
//   Registered immediate-extraction stage with a two-entry skid buffer.
//   The immediate is computed on the input side and stored with its illegal
//   flag and tag; the head entry is presented on out_*.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     flush               drop every buffered entry and any same-cycle input
//     in_valid/in_ready   input handshake (in_ready is registered)
//     in_instr            instruction word, bits [6:0] ignored
//     in_imm_type         immediate format (imm_type_e encoding)
//     in_tag              sideband tag, passed through unchanged
//     out_valid/out_ready output handshake for the head entry
//     out_imm             extended immediate of the head entry
//     out_illegal         head entry requested the reserved format
//     out_tag             tag of the head entry
//   All out_* payloads read 0 while the buffer is empty.
// -----------------------------------------------------------------------------
module imm_decode_stage
    import rvcam_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [IMM_TYPE_W-1:0] in_imm_type,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_imm,
    output logic                  out_illegal,
    output logic [TAG_W-1:0]      out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  w_in_imm;
    logic             w_in_illegal;
    logic             w_unused_opcode;

    assign w_unused_opcode = ^in_instr[6:0];

    imm_expand #(
        .XLEN (XLEN)
    ) u_imm_expand (
        .i_instr    (in_instr[31:7]),
        .i_imm_type (imm_type_e'(in_imm_type)),
        .o_imm      (w_in_imm),
        .o_illegal  (w_in_illegal)
    );

    // ---- skid buffer: slot 0 is always the head entry ----
    logic [1:0]       r_count;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_imm [2];
    logic             r_ill [2];
    logic [TAG_W-1:0] r_tag [2];

    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_idx;
    logic [1:0]       w_count_nxt;

    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = in_valid && r_in_ready && !flush;
    assign w_pop       = w_out_valid && out_ready && !flush;
    // A push lands behind the surviving entries: slot 1 only when one entry
    // stays in the buffer this cycle.
    assign w_wr_idx    = (r_count == 2'd1) && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + 2'd1;
                2'b01:   w_count_nxt = r_count - 2'd1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    // Payload carries no reset; the output mask hides it while empty.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_imm[0] <= r_imm[1];
            r_ill[0] <= r_ill[1];
            r_tag[0] <= r_tag[1];
        end
        if (w_push) begin
            if (w_wr_idx) begin
                r_imm[1] <= w_in_imm;
                r_ill[1] <= w_in_illegal;
                r_tag[1] <= in_tag;
            end else begin
                r_imm[0] <= w_in_imm;
                r_ill[0] <= w_in_illegal;
                r_tag[0] <= in_tag;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign out_imm     = w_out_valid ? r_imm[0] : '0;
    assign out_illegal = w_out_valid ? r_ill[0] : 1'b0;
    assign out_tag     = w_out_valid ? r_tag[0] : '0;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_type;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        r32_in_ready, r32_out_valid, r32_out_illegal;
    logic [31:0] r32_out_imm;
    logic [7:0]  r32_out_tag;
    logic        r64_in_ready, r64_out_valid, r64_out_illegal;
    logic [63:0] r64_out_imm;
    logic [7:0]  r64_out_tag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] imm;
        logic        ill;
        logic [7:0]  tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r32_in_ready),
        .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(r32_out_valid), .out_ready(out_ready),
        .out_imm(r32_out_imm), .out_illegal(r32_out_illegal), .out_tag(r32_out_tag)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(r64_in_ready),
        .in_instr(in_instr), .in_imm_type(in_imm_type), .in_tag(in_tag),
        .out_valid(r64_out_valid), .out_ready(out_ready),
        .out_imm(r64_out_imm), .out_illegal(r64_out_illegal), .out_tag(r64_out_tag)
    );

    // Reference: build a 64-bit value directly from the bit scatter, then
    // truncate for the 32-bit datapath.
    function automatic exp_t model(input int xlen, input logic [31:0] ins,
                                   input logic [2:0] t, input logic [7:0] tag);
        exp_t e;
        logic s;
        s = ins[31];
        e.ill = 1'b0;
        e.tag = tag;
        case (t)
            3'd0: e.imm = {{52{s}}, ins[31:20]};
            3'd1: e.imm = {{52{s}}, ins[31:25], ins[11:7]};
            3'd2: e.imm = {{51{s}}, s, ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: e.imm = {{32{s}}, ins[31:12], 12'h000};
            3'd4: e.imm = {{43{s}}, s, ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd5: e.imm = {59'd0, ins[19:15]};
            3'd6: e.imm = (xlen == 64) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
            default: begin e.imm = 64'd0; e.ill = 1'b1; end
        endcase
        if (xlen == 32) e.imm = {32'd0, e.imm[31:0]};
        return e;
    endfunction

    // Scoreboard: outputs leaving at the coming edge are compared against the
    // queue head, then entries entering at that edge are queued.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q32.delete();
            q64.delete();
        end else begin
            if (r32_out_valid && out_ready) begin
                checks++;
                if (q32.size() == 0) begin
                    failures++;
                    $display("FAIL sb32_unexpected: got tag=%0d imm=%h, expected no output", r32_out_tag, r32_out_imm);
                end else begin
                    exp_t e;
                    e = q32.pop_front();
                    if (r32_out_imm !== e.imm[31:0] || r32_out_illegal !== e.ill || r32_out_tag !== e.tag) begin
                        failures++;
                        $display("FAIL sb32_entry: got imm=%h ill=%b tag=%0d, expected imm=%h ill=%b tag=%0d",
                                 r32_out_imm, r32_out_illegal, r32_out_tag, e.imm[31:0], e.ill, e.tag);
                    end
                end
            end
            if (r64_out_valid && out_ready) begin
                checks++;
                if (q64.size() == 0) begin
                    failures++;
                    $display("FAIL sb64_unexpected: got tag=%0d imm=%h, expected no output", r64_out_tag, r64_out_imm);
                end else begin
                    exp_t e;
                    e = q64.pop_front();
                    if (r64_out_imm !== e.imm || r64_out_illegal !== e.ill || r64_out_tag !== e.tag) begin
                        failures++;
                        $display("FAIL sb64_entry: got imm=%h ill=%b tag=%0d, expected imm=%h ill=%b tag=%0d",
                                 r64_out_imm, r64_out_illegal, r64_out_tag, e.imm, e.ill, e.tag);
                    end
                end
            end
            if (in_valid && r32_in_ready) q32.push_back(model(32, in_instr, in_imm_type, in_tag));
            if (in_valid && r64_in_ready) q64.push_back(model(64, in_instr, in_imm_type, in_tag));
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_imm_type = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (r32_out_valid !== 1'b0 || r64_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b/%b, expected 0/0", r32_out_valid, r64_out_valid);
        end
        checks++;
        if (r32_in_ready !== 1'b1 || r64_in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b/%b, expected 1/1", r32_in_ready, r64_in_ready);
        end
        checks++;
        if (r32_out_imm !== 32'd0 || r64_out_imm !== 64'd0 || r32_out_illegal !== 1'b0 ||
            r64_out_illegal !== 1'b0 || r32_out_tag !== 8'd0 || r64_out_tag !== 8'd0) begin
            failures++; $display("FAIL reset_payload: got imm=%h/%h ill=%b/%b tag=%0d/%0d, expected all 0",
                                 r32_out_imm, r64_out_imm, r32_out_illegal, r64_out_illegal, r32_out_tag, r64_out_tag);
        end
    endtask

    task automatic test_formats();
        logic [31:0] ins [7]  = '{32'hFFF00093, 32'hFE000EE3, 32'h12345037, 32'h80000037,
                                  32'h03F09093, 32'h000FD073, 32'hFFFFFFFF};
        logic [2:0]  typ [7]  = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd6, 3'd5, 3'd7};
        logic [31:0] e32 [7]  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h80000000,
                                  32'd31, 32'h1F, 32'd0};
        logic [63:0] e64 [7]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000,
                                  64'hFFFFFFFF80000000, 64'd63, 64'h1F, 64'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_instr = ins[i]; in_imm_type = typ[i]; in_tag = 8'(8'h40 + i);
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (r32_out_valid !== 1'b1 || r32_out_imm !== e32[i] || r32_out_illegal !== (typ[i] == 3'd7) ||
                r32_out_tag !== 8'(8'h40 + i)) begin
                failures++;
                $display("FAIL fmt32_%0d: got v=%b imm=%h ill=%b tag=%h, expected v=1 imm=%h ill=%b tag=%h",
                         i, r32_out_valid, r32_out_imm, r32_out_illegal, r32_out_tag, e32[i], typ[i] == 3'd7, 8'(8'h40 + i));
            end
            checks++;
            if (r64_out_valid !== 1'b1 || r64_out_imm !== e64[i] || r64_out_illegal !== (typ[i] == 3'd7) ||
                r64_out_tag !== 8'(8'h40 + i)) begin
                failures++;
                $display("FAIL fmt64_%0d: got v=%b imm=%h ill=%b tag=%h, expected v=1 imm=%h ill=%b tag=%h",
                         i, r64_out_valid, r64_out_imm, r64_out_illegal, r64_out_tag, e64[i], typ[i] == 3'd7, 8'(8'h40 + i));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_two(input logic [7:0] t0);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_instr = $urandom; in_imm_type = 3'($urandom_range(0, 7)); in_tag = 8'(t0 + k);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0 || r32_out_valid || r64_out_valid) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL %s_drain: got %0d/%0d entries pending after 20 cycles, expected 0", name, q32.size(), q64.size());
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = 32'h00100093; in_imm_type = 3'd0; in_tag = 8'd1;
        @(posedge clk); #1;
        in_tag = 8'd2; in_instr = 32'h00200093;
        @(posedge clk); #1;
        in_tag = 8'd3; in_instr = 32'h00300093;
        checks++;
        if (r32_in_ready !== 1'b0 || r64_in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_in_ready_low: got %b/%b, expected 0/0", r32_in_ready, r64_in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (r32_out_tag !== 8'd1 || r64_out_tag !== 8'd1 || r32_out_imm !== 32'd1 || r64_out_imm !== 64'd1) begin
            failures++; $display("FAIL bp_head_hold: got tag=%0d/%0d imm=%h/%h, expected tag 1 imm 1",
                                 r32_out_tag, r64_out_tag, r32_out_imm, r64_out_imm);
        end
        checks++;
        if (r32_in_ready !== 1'b0 || q32.size() != 2) begin
            failures++; $display("FAIL bp_held_off: got in_ready=%b queued=%0d, expected 0 and 2", r32_in_ready, q32.size());
        end
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (n < 10) begin
                @(negedge clk);
                if (r32_in_ready) break;
                n++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("bp");
    endtask

    task automatic test_flush();
        fill_two(8'd20);
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = 32'h00900093; in_imm_type = 3'd0; in_tag = 8'd9; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (r32_out_valid !== 1'b0 || r64_out_valid !== 1'b0 || r32_in_ready !== 1'b1 || r64_in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_state: got valid=%b/%b ready=%b/%b, expected valid 0 ready 1",
                                 r32_out_valid, r64_out_valid, r32_in_ready, r64_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (r32_out_valid !== 1'b0 || r64_out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_discard: got valid=%b/%b tag=%0d, expected valid 0", r32_out_valid, r64_out_valid, r32_out_tag);
        end
    endtask

    task automatic test_async_reset();
        fill_two(8'd30);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (r32_out_valid !== 1'b0 || r64_out_valid !== 1'b0) begin
            failures++; $display("FAIL areset_immediate: got valid=%b/%b, expected 0/0", r32_out_valid, r64_out_valid);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        checks++;
        if (r32_in_ready !== 1'b1 || r64_in_ready !== 1'b1) begin
            failures++; $display("FAIL areset_ready: got %b/%b, expected 1/1", r32_in_ready, r64_in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = 32'h80000037; in_imm_type = 3'd3; in_tag = 8'd77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (r32_out_valid !== 1'b1 || r32_out_tag !== 8'd77 || r64_out_imm !== 64'hFFFFFFFF80000000) begin
            failures++; $display("FAIL areset_latency: got v=%b tag=%0d imm=%h, expected v=1 tag=77 imm=ffffffff80000000",
                                 r32_out_valid, r32_out_tag, r64_out_imm);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int stalls;
        stalls = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!r32_in_ready) stalls++;
            in_valid = 1'b1; in_instr = $urandom; in_imm_type = 3'($urandom_range(0, 7)); in_tag = 8'(100 + i);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (stalls != 0) begin
            failures++; $display("FAIL b2b_throughput: got %0d stall cycles, expected 0", stalls);
        end
        drain("b2b");
    endtask

    task automatic test_random_stream();
        int sent, cyc;
        logic acc;
        sent = 0; cyc = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = $urandom; in_imm_type = 3'($urandom_range(0, 7)); in_tag = 8'(200);
        while (sent < 24 && cyc < 500) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && r32_in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                in_instr = $urandom; in_imm_type = 3'($urandom_range(0, 7)); in_tag = 8'(200 + sent);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (sent < 24) begin
            failures++; $display("FAIL rand_progress: got %0d accepted in 500 cycles, expected 24", sent);
        end
        drain("rand");
    endtask

    initial begin
        test_reset();
        test_formats();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
